// File: rtl/sram_controller_if.sv
// MEM-stage request/response bus of the off-chip data-memory controller.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Data-memory controller for a 16-bit asynchronous SRAM. Each 32-bit word
// access is split into a low-half and a high-half SRAM cycle, each lasting
// WAIT_CYCLES clocks. ready is held low while an access is in flight so the
// pipeline freeze logic stalls every stage.
module sram_controller #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q;
  logic [31:0]   rdata_q;

  logic          req;
  logic          last;
  logic [31:0]   offset;
  logic          unused_addr_bits;
  logic          dq_oe;
  logic [15:0]   dq_out;

  assign req  = bus.rd_en | bus.wr_en;
  assign last = (cnt_q == CW'(WAIT_CYCLES - 1));

  // Word index relative to the mapped base; the byte offset inside the word
  // and any word bits beyond the SRAM depth are discarded, so addresses wrap.
  assign offset           = bus.address - 32'(ADDR_BASE);
  assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

  assign bus.read_data = rdata_q;

  // State, wait counter and operation type (latched when leaving IDLE).
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses <= so every flop updates from pre-edge values.
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) wr_q <= bus.wr_en;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = LOW;
        cnt_d   = '0;
      end
      LOW: if (last) begin
        state_d = HIGH;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      HIGH: if (last) state_d = DONE;
            else      cnt_d   = cnt_q + 1'b1;
      DONE: state_d = IDLE;
    endcase
  end

  // SRAM strobes, address, data drive and the ready handshake.
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = (state_q == HIGH) ? bus.write_data[31:16] : bus.write_data[15:0];
    SRAM_ADDR = {offset[SRAM_AW:2], state_q == HIGH};
    bus.ready = 1'b0;
    unique case (state_q)
      IDLE: bus.ready = ~req;
      LOW, HIGH: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = wr_q;
        SRAM_WE_N = ~wr_q;
        dq_oe     = wr_q;
      end
      DONE: bus.ready = 1'b1;
    endcase
  end

  // Load data: each half is captured on the final clock of its SRAM cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (!wr_q && last) begin
      if (state_q == LOW)       rdata_q[15:0]  <= SRAM_DQ;
      else if (state_q == HIGH) rdata_q[31:16] <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (1 and 3 wait states), each on a
// behavioural asynchronous SRAM, with a read-data scoreboard.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_controller_if bus1 ();
  sram_controller_if bus3 ();

  wire  [15:0] dq1, dq3;
  logic [17:0] a1, a3;
  logic        we1, oe1, ce1, ub1, lb1;
  logic        we3, oe3, ce3, ub3, lb3;

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .SRAM_DQ(dq1), .SRAM_ADDR(a1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1),
    .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
  );

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(3), .SRAM_AW(18)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave),
    .SRAM_DQ(dq3), .SRAM_ADDR(a3), .SRAM_WE_N(we3), .SRAM_OE_N(oe3),
    .SRAM_CE_N(ce3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3)
  );

  // Behavioural SRAMs: combinational read, write on a clock where CE/WE are low.
  logic [15:0] sram1 [0:(1<<18)-1];
  logic [15:0] sram3 [0:(1<<18)-1];
  assign dq1 = (!ce1 && !oe1 && we1) ? sram1[a1] : 16'hzzzz;
  assign dq3 = (!ce3 && !oe3 && we3) ? sram3[a3] : 16'hzzzz;
  always @(posedge clk) if (!ce1 && !we1) sram1[a1] <= dq1;
  always @(posedge clk) if (!ce3 && !we3) sram3[a3] <= dq3;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [int];
  logic [31:0] last_rd [2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return off[18:2];
  endfunction

  function automatic logic        get_ready(input bit sel); return sel ? bus3.ready : bus1.ready; endfunction
  function automatic logic [31:0] get_rdata(input bit sel); return sel ? bus3.read_data : bus1.read_data; endfunction
  function automatic logic        get_ce(input bit sel);    return sel ? ce3 : ce1; endfunction
  function automatic logic        get_oe(input bit sel);    return sel ? oe3 : oe1; endfunction
  function automatic logic        get_we(input bit sel);    return sel ? we3 : we1; endfunction
  function automatic logic [17:0] get_addr(input bit sel);  return sel ? a3 : a1; endfunction
  function automatic logic [15:0] get_mem(input bit sel, input logic [17:0] a);
    return sel ? sram3[a] : sram1[a];
  endfunction

  task automatic drive(input bit sel, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      bus3.wr_en = w; bus3.rd_en = r; bus3.address = a; bus3.write_data = d;
    end else begin
      bus1.wr_en = w; bus1.rd_en = r; bus1.address = a; bus1.write_data = d;
    end
  endtask

  // One full access, entered just after a rising edge with the DUT in IDLE.
  task automatic access(input bit sel, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d, input bit keep);
    int          k;
    int          wc;
    int          key;
    logic [16:0] wd;
    logic [31:0] e;
    wc  = sel ? 3 : 1;
    wd  = word_of(a);
    key = int'(wd) + (sel ? 32'h100000 : 32'h0);
    drive(sel, w, r, a, d);
    if (r && !w) exp_q.push_back(model[key]);
    k = 0;
    @(negedge clk);
    while (get_ready(sel) !== 1'b1 && k < 40) begin
      if (k >= 1) begin
        check("ce_n", 32'(get_ce(sel)), 32'd0);
        check("oe_n", 32'(get_oe(sel)), 32'(w));
        check("we_n", 32'(get_we(sel)), 32'(!w));
        check("sram_addr", 32'(get_addr(sel)), 32'({wd, k > wc}));
      end
      k++;
      @(negedge clk);
    end
    check("busy_cycles", k, 2 * wc + 1);
    check("done_ce_n", 32'(get_ce(sel)), 32'd1);
    if (w) begin
      model[key] = d;
      check("sram_lo", 32'(get_mem(sel, {wd, 1'b0})), 32'(d[15:0]));
      check("sram_hi", 32'(get_mem(sel, {wd, 1'b1})), 32'(d[31:16]));
      check("rd_unchanged", get_rdata(sel), last_rd[sel]);
    end else if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("read_data", get_rdata(sel), e);
      last_rd[sel] = e;
    end
    @(posedge clk);
    #1;
    if (!keep) drive(sel, 1'b0, 1'b0, a, d);
  endtask

  // One idle cycle with no request: ready high, chip deselected, data held.
  task automatic idle_gap(input bit sel);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("idle_ready", 32'(get_ready(sel)), 32'd1);
    check("idle_ce_n", 32'(get_ce(sel)), 32'd1);
    check("rd_hold", get_rdata(sel), last_rd[sel]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #12;
    check("rst_read_data", bus1.read_data, 32'd0);
    check("rst_ready", 32'(bus1.ready), 32'd1);
    check("rst_ce_n", 32'(ce1), 32'd1);
    check("rst_oe_n", 32'(oe1), 32'd1);
    check("rst_we_n", 32'(we1), 32'd1);
    check("ub_lb_tied", 32'({ub1, lb1, ub3, lb3}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Store then load, wait states = 1.
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    idle_gap(1'b0);

    // Address mapping, including an unaligned byte address.
    access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'd1031, 32'hAAAA5555, 1'b0);

    // Both enables high: the write wins, read_data untouched.
    access(1'b0, 1'b1, 1'b1, 32'd1040, 32'h0BADF00D, 1'b0);
    idle_gap(1'b0);

    // Back-to-back loads with rd_en held across both.
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    idle_gap(1'b0);

    // Out-of-range address wraps onto word 0.
    access(1'b0, 1'b0, 1'b1, 32'd1024 + (32'd1 << 19), 32'h0, 1'b0);
    idle_gap(1'b0);

    // Reset asserted during the high half of a load.
    drive(1'b0, 1'b0, 1'b1, 32'd1040, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_ce_n", 32'(ce1), 32'd1);
    check("midrst_oe_n", 32'(oe1), 32'd1);
    check("midrst_we_n", 32'(we1), 32'd1);
    check("midrst_read_data", bus1.read_data, 32'd0);
    check("midrst_ready_req", 32'(bus1.ready), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("midrst_ready_idle", 32'(bus1.ready), 32'd1);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    idle_gap(1'b0);

    // Three wait states per half access.
    access(1'b1, 1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 1'b0);
    access(1'b1, 1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
    idle_gap(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
